// File: rtl/pipe_hazard_ctrl.sv
// Stage-2 hazard/exception controller: load-use stalls, multi-cycle branch flushes, sticky exception capture with HALTED hold.
// Optional PIPE_HAZ_EXC_CNT_EN adds saturating exc_count/stall_count outputs.
module pipe_hazard_ctrl #(
    parameter int PC_W        = 16,
    parameter int REG_AW      = 4,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        comparator,
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] ifid_op1,
    input  logic [REG_AW-1:0] ifid_op2,
    input  logic [REG_AW-1:0] idex_dest,
    input  logic              idex_mem_read,
    input  logic              alu_exception,
    input  logic [PC_W-1:0]   pc,
    input  logic              resume,
    output logic              change_pc,
    output logic              mem_bubble,
    output logic              pc_bubble,
    output logic              halt,
    output logic [PC_W-1:0]   ex_pc,
    output logic [15:0]       ex_error_val,
    output logic              busy
`ifdef PIPE_HAZ_EXC_CNT_EN
    ,
    output logic [7:0]        exc_count,
    output logic [15:0]       stall_count
`endif
);

    localparam int CNT_MAX = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALTED} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic [15:0]       ex_err_q, ex_err_d;
    logic              load_use, br_taken, op_legal;

    always_comb begin
        load_use = (LOAD_LAT > 0) && idex_mem_read &&
                   ((idex_dest == ifid_op1) || (idex_dest == ifid_op2));
        br_taken = (opcode == 4'b0001) ||
                   ((opcode == 4'b0101) && (comparator == 2'b01)) ||
                   ((opcode == 4'b0100) && (comparator == 2'b10)) ||
                   ((opcode == 4'b0110) && (comparator == 2'b11));
        case (opcode)
            4'b0010, 4'b0011, 4'b0111, 4'b1110: op_legal = 1'b0;
            default:                            op_legal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_pc_d    = ex_pc_q;
        ex_err_d   = ex_err_q;
        change_pc  = 1'b0;
        mem_bubble = 1'b0;
        pc_bubble  = 1'b0;
        halt       = 1'b0;
        // Outputs are forced quiet while reset is held, independent of inputs.
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        mem_bubble = 1'b1;
                        pc_bubble  = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = CNT_W'(LOAD_LAT - 1);
                        end
                    end else if (br_taken) begin
                        change_pc  = 1'b1;
                        mem_bubble = 1'b1;
                        if (FLUSH_DEPTH > 1) begin
                            state_d = FLUSH;
                            cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
                        end
                    end else if (opcode == 4'b0000) begin
                        halt     = 1'b1;
                        state_d  = HALTED;
                        ex_pc_d  = pc - PC_W'(2);
                        ex_err_d = 16'h0001;
                    end else if (alu_exception) begin
                        halt     = 1'b1;
                        state_d  = HALTED;
                        ex_pc_d  = pc - PC_W'(4);
                        ex_err_d = 16'hAFFF;
                    end else if (!op_legal) begin
                        halt     = 1'b1;
                        state_d  = HALTED;
                        ex_pc_d  = pc - PC_W'(2);
                        ex_err_d = 16'hC000;
                    end
                end
                STALL, FLUSH: begin
                    // Overflow of the instruction already in EX preempts the remaining bubbles.
                    if (alu_exception) begin
                        halt     = 1'b1;
                        state_d  = HALTED;
                        cnt_d    = '0;
                        ex_pc_d  = pc - PC_W'(4);
                        ex_err_d = 16'hAFFF;
                    end else begin
                        mem_bubble = 1'b1;
                        pc_bubble  = (state_q == STALL);
                        cnt_d      = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
                HALTED: begin
                    halt = 1'b1;
                    if (resume) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            ex_pc_q  <= '0;
            ex_err_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ex_pc_q  <= ex_pc_d;
            ex_err_q <= ex_err_d;
        end
    end

    assign ex_pc        = ex_pc_q;
    assign ex_error_val = ex_err_q;
    assign busy         = (state_q == STALL) || (state_q == FLUSH);

`ifdef PIPE_HAZ_EXC_CNT_EN
    logic [7:0]  exc_count_q, exc_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        exc_count_d   = exc_count_q;
        stall_count_d = stall_count_q;
        if ((state_d == HALTED) && (state_q != HALTED) && (exc_count_q != 8'hFF)) begin
            exc_count_d = exc_count_q + 8'd1;
        end
        if (pc_bubble && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            exc_count_q   <= exc_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign exc_count   = exc_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (LOAD_LAT=3, FLUSH_DEPTH=2) with a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;

    localparam int LL = 3;
    localparam int FD = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  comparator;
    logic [3:0]  opcode;
    logic [3:0]  ifid_op1, ifid_op2, idex_dest;
    logic        idex_mem_read, alu_exception, resume;
    logic [15:0] pc;
    logic        change_pc, mem_bubble, pc_bubble, halt, busy;
    logic [15:0] ex_pc, ex_error_val;
`ifdef PIPE_HAZ_EXC_CNT_EN
    logic [7:0]  exc_count;
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(
        .PC_W(16), .REG_AW(4), .LOAD_LAT(LL), .FLUSH_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .comparator(comparator), .opcode(opcode),
        .ifid_op1(ifid_op1), .ifid_op2(ifid_op2), .idex_dest(idex_dest),
        .idex_mem_read(idex_mem_read), .alu_exception(alu_exception), .pc(pc),
        .resume(resume), .change_pc(change_pc), .mem_bubble(mem_bubble),
        .pc_bubble(pc_bubble), .halt(halt), .ex_pc(ex_pc),
        .ex_error_val(ex_error_val), .busy(busy)
`ifdef PIPE_HAZ_EXC_CNT_EN
        , .exc_count(exc_count), .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stall/flush windows are tracked as absolute cycle ranges.
    int          cyc = 0;
    int          stall_until = 0;
    int          flush_until = 0;
    bit          m_halted = 0;
    logic [15:0] m_ex_pc = 16'h0;
    logic [15:0] m_err = 16'h0;
    int          m_exc = 0;
    int          m_stall = 0;

    task automatic enter_halt(input logic [15:0] epc, input logic [15:0] code);
        m_halted    = 1'b1;
        m_ex_pc     = epc;
        m_err       = code;
        stall_until = 0;
        flush_until = 0;
        if (m_exc < 255) m_exc++;
    endtask

    always @(negedge clk) begin : model_cmp
        logic e_cp, e_mb, e_pb, e_h, e_busy, luse, take, legal;
        if (rst) begin
            stall_until = 0; flush_until = 0; m_halted = 0;
            m_ex_pc = 16'h0; m_err = 16'h0; m_exc = 0; m_stall = 0;
        end
        e_busy = !rst && !m_halted && ((cyc < stall_until) || (cyc < flush_until));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ex_pc", 32'(ex_pc), 32'(m_ex_pc));
        chk("ex_error_val", 32'(ex_error_val), 32'(m_err));
`ifdef PIPE_HAZ_EXC_CNT_EN
        chk("exc_count", 32'(exc_count), 32'(m_exc));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
        e_cp = 0; e_mb = 0; e_pb = 0; e_h = 0;
        if (!rst) begin
            if (m_halted) begin
                e_h = 1;
                if (resume) m_halted = 0;
            end else if (e_busy) begin
                if (alu_exception) begin
                    e_h = 1;
                    enter_halt(pc - 16'd4, 16'hAFFF);
                end else if (cyc < stall_until) begin
                    e_mb = 1; e_pb = 1;
                end else begin
                    e_mb = 1;
                end
            end else begin
                luse  = (LL > 0) && idex_mem_read && (idex_dest == ifid_op1 || idex_dest == ifid_op2);
                take  = (opcode == 4'd1) || (opcode == 4'd5 && comparator == 2'd1) ||
                        (opcode == 4'd4 && comparator == 2'd2) || (opcode == 4'd6 && comparator == 2'd3);
                legal = (opcode == 4'd15) || (opcode >= 4'd8 && opcode <= 4'd13) || (opcode == 4'd5) ||
                        (opcode == 4'd4) || (opcode == 4'd6) || (opcode == 4'd1) || (opcode == 4'd0);
                if (luse) begin
                    e_mb = 1; e_pb = 1; stall_until = cyc + LL;
                end else if (take) begin
                    e_cp = 1; e_mb = 1; flush_until = cyc + FD;
                end else if (opcode == 4'd0) begin
                    e_h = 1; enter_halt(pc - 16'd2, 16'h0001);
                end else if (alu_exception) begin
                    e_h = 1; enter_halt(pc - 16'd4, 16'hAFFF);
                end else if (!legal) begin
                    e_h = 1; enter_halt(pc - 16'd2, 16'hC000);
                end
            end
        end
        chk("change_pc", 32'(change_pc), 32'(e_cp));
        chk("mem_bubble", 32'(mem_bubble), 32'(e_mb));
        chk("pc_bubble", 32'(pc_bubble), 32'(e_pb));
        chk("halt", 32'(halt), 32'(e_h));
        if (e_pb && m_stall < 16'hFFFF) m_stall++;
        cyc++;
    end

    task automatic idle();
        comparator = 2'b00; opcode = 4'b1000; ifid_op1 = 4'd1; ifid_op2 = 4'd2;
        idex_dest = 4'd0; idex_mem_read = 1'b0; alu_exception = 1'b0;
        pc = 16'h0200; resume = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input logic [3:0] op, input logic [1:0] cmp, input logic mr,
                       input logic [3:0] d, input logic [3:0] o1, input logic [3:0] o2);
        tick(); idle();
        opcode = op; comparator = cmp; idex_mem_read = mr;
        idex_dest = d; ifid_op1 = o1; ifid_op2 = o2;
        repeat (4) begin tick(); idle(); end
    endtask

    task automatic exc(input logic [3:0] op, input logic alu, input logic [15:0] pcv);
        tick(); idle();
        opcode = op; alu_exception = alu; pc = pcv;
        tick(); idle(); resume = 1'b1;
        tick(); idle();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [4:0] pb, mb, bz, cp;
        int hcnt;
        rst = 1'b1;
        idle();
        tick(); tick();
        @(negedge clk);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_ex_pc", 32'(ex_pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick(); rst = 1'b0;

        // Load-use on op2: three bubble cycles, busy for the last two.
        tick(); idle(); idex_mem_read = 1'b1; idex_dest = 4'd5; ifid_op2 = 4'd5;
        pb = '0; mb = '0; bz = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); pb[i] = pc_bubble; mb[i] = mem_bubble; bz[i] = busy;
            tick(); idle();
        end
        chk("lu_pc_bubble", 32'(pb), 32'(5'b00111));
        chk("lu_mem_bubble", 32'(mb), 32'(5'b00111));
        chk("lu_busy", 32'(bz), 32'(5'b00110));

        // Taken BEQ: one redirect, two bubbles.
        tick(); idle(); opcode = 4'b0110; comparator = 2'b11;
        cp = '0; mb = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); cp[i] = change_pc; mb[i] = mem_bubble;
            tick(); idle();
        end
        chk("beq_change_pc", 32'(cp), 32'(5'b00001));
        chk("beq_mem_bubble", 32'(mb), 32'(5'b00011));
        tick(); idle(); opcode = 4'b0110; comparator = 2'b01;
        @(negedge clk);
        chk("beq_nt_change_pc", 32'(change_pc), 32'd0);
        chk("beq_nt_mem_bubble", 32'(mem_bubble), 32'd0);
        tick(); idle();

        vec(4'b0101, 2'b01, 1'b0, 4'd0, 4'd1, 4'd2);
        vec(4'b0101, 2'b10, 1'b0, 4'd0, 4'd1, 4'd2);
        vec(4'b0100, 2'b10, 1'b0, 4'd0, 4'd1, 4'd2);
        vec(4'b0100, 2'b11, 1'b0, 4'd0, 4'd1, 4'd2);
        vec(4'b0001, 2'b00, 1'b0, 4'd0, 4'd1, 4'd2);
        vec(4'b1111, 2'b11, 1'b0, 4'd0, 4'd1, 4'd2);
        vec(4'b1101, 2'b01, 1'b0, 4'd0, 4'd1, 4'd2);
        vec(4'b0001, 2'b00, 1'b1, 4'd7, 4'd7, 4'd3);
        vec(4'b0110, 2'b11, 1'b1, 4'd7, 4'd1, 4'd2);
        vec(4'b1000, 2'b00, 1'b0, 4'd3, 4'd3, 4'd3);

        // HALT at 0x0040, held for ten cycles while hazards are presented.
        tick(); idle(); opcode = 4'b0000; pc = 16'h0040;
        @(negedge clk);
        chk("halt_same_cycle", 32'(halt), 32'd1);
        tick(); idle();
        @(negedge clk);
        chk("halt_ex_pc", 32'(ex_pc), 32'h003E);
        chk("halt_ex_err", 32'(ex_error_val), 32'h0001);
        hcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); idle(); opcode = 4'b0001; idex_mem_read = 1'b1; idex_dest = 4'd1;
            @(negedge clk); hcnt += int'(halt);
        end
        chk("halt_held_cycles", 32'(hcnt), 32'd10);
        tick(); idle(); resume = 1'b1;
        tick(); idle();
        @(negedge clk);
        chk("resume_halt", 32'(halt), 32'd0);
        chk("resume_sticky_pc", 32'(ex_pc), 32'h003E);

        // Overflow during FLUSH.
        tick(); idle(); opcode = 4'b0001;
        tick(); idle(); alu_exception = 1'b1; pc = 16'h0010; opcode = 4'b0001;
        @(negedge clk);
        chk("flush_exc_halt", 32'(halt), 32'd1);
        tick(); idle();
        @(negedge clk);
        chk("flush_exc_pc", 32'(ex_pc), 32'h000C);
        chk("flush_exc_err", 32'(ex_error_val), 32'hAFFF);
        tick(); idle(); resume = 1'b1;
        tick(); idle();
        @(negedge clk);
        chk("flush_resume_halt", 32'(halt), 32'd0);
        chk("flush_resume_pc", 32'(ex_pc), 32'h000C);

        // Overflow during STALL, then assorted RUN exceptions.
        tick(); idle(); idex_mem_read = 1'b1; idex_dest = 4'd1;
        tick(); idle(); alu_exception = 1'b1; pc = 16'h0002;
        tick(); idle(); resume = 1'b1;
        tick(); idle();
        exc(4'b1000, 1'b1, 16'h0002);
        @(negedge clk);
        chk("ovf_wrap_pc", 32'(ex_pc), 32'hFFFE);
        exc(4'b0000, 1'b1, 16'h0100);
        exc(4'b0010, 1'b0, 16'h0100);
        exc(4'b0111, 1'b0, 16'h0104);
        exc(4'b1110, 1'b0, 16'h0108);

        // Illegal opcode at pc 0, then asynchronous reset mid-cycle.
        tick(); idle(); opcode = 4'b0011; pc = 16'h0000;
        tick(); idle();
        @(negedge clk);
        chk("ill_ex_pc", 32'(ex_pc), 32'hFFFE);
        chk("ill_ex_err", 32'(ex_error_val), 32'hC000);
        tick(); #3; rst = 1'b1; #1;
        chk("arst_halt", 32'(halt), 32'd0);
        chk("arst_ex_pc", 32'(ex_pc), 32'd0);
        chk("arst_ex_err", 32'(ex_error_val), 32'd0);
        tick(); rst = 1'b0;

`ifdef PIPE_HAZ_EXC_CNT_EN
        tick(); idle(); idex_mem_read = 1'b1; idex_dest = 4'd2;
        repeat (4) begin tick(); idle(); end
        @(negedge clk);
        chk("stall_count_lu", 32'(stall_count), 32'd3);
        for (int i = 0; i < 300; i++) begin
            tick(); idle(); opcode = 4'b0000;
            tick(); idle(); resume = 1'b1;
        end
        tick(); idle();
        @(negedge clk);
        chk("exc_count_sat", 32'(exc_count), 32'hFF);
`endif

        tick(); idle(); tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Second-generation stage-2 hazard/exception controller for the 16-bit pipelined datapath.
- Generalises the combinational hazard unit: PC width, register-address width, load-use stall length and branch flush depth are parameters.
- Multi-cycle stalls and flushes are sequenced by a state machine.
- Exceptions are captured into sticky registers and held in a HALTED state until software/bench resume.

Parameters:
- PC_W, 16: PC and exception-PC width.
- REG_AW, 4: register-address width.
- LOAD_LAT, 1: bubble cycles inserted on a load-use hazard; 0 disables load-use stalls.
- FLUSH_DEPTH, 1: bubble cycles after a taken branch/jump, including the decision cycle; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- comparator  in  2  01 less, 10 greater, 11 equal, 00 none
- opcode  in  4  ID-stage opcode
- ifid_op1, ifid_op2  in  REG_AW  IF/ID source registers
- idex_dest  in  REG_AW  ID/EX load destination register
- idex_mem_read  in  1  ID/EX instruction is a load
- alu_exception  in  1  EX overflow
- pc  in  PC_W  current PC
- resume  in  1  leave HALTED (pulse)
- change_pc  out  1  redirect fetch to branch/jump target
- mem_bubble  out  1  insert bubble into ID/EX
- pc_bubble  out  1  freeze PC and IF/ID
- halt  out  1  pipeline halted
- ex_pc  out  PC_W  captured exception PC
- ex_error_val  out  16  captured cause code
- busy  out  1  state is STALL or FLUSH

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state RUN, counter 0, ex_pc 0, ex_error_val 0. All control outputs are 0 after reset.
- States: RUN, STALL, FLUSH, HALTED.
- change_pc, mem_bubble and pc_bubble are combinational from state and inputs. ex_pc and ex_error_val are registered.

RUN priority order; the first match wins:
1. Load-use: idex_mem_read and idex_dest equals ifid_op1 or ifid_op2, with LOAD_LAT>0.
   - mem_bubble=pc_bubble=1 this cycle.
   - If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
2. Taken branch:
   - BLT (0101) with comparator 01, BGT (0100) with 10, BEQ (0110) with 11, or JMP (0001).
   - change_pc=mem_bubble=1 this cycle.
   - If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1.
3. HALT opcode (0000): capture ex_pc=pc-2 and ex_error_val=0x0001.
4. alu_exception: capture ex_pc=pc-4 and ex_error_val=0xAFFF.
5. Illegal opcode: any opcode outside {1111, 1000-1101, 0101, 0100, 0110, 0001, 0000}. Capture ex_pc=pc-2 and ex_error_val=0xC000.

Exception handling (cases 3-5):
- halt=1 combinationally in the detection cycle.
- Go to HALTED at the next edge; captures land on that same edge.

STALL:
- mem_bubble=pc_bubble=1 every cycle; cnt decrements.
- The cycle with cnt==1 is the last; return to RUN.
- Total stall is exactly LOAD_LAT cycles.

FLUSH:
- mem_bubble=1, change_pc=0, pc_bubble=0; cnt decrements as in STALL.
- Total bubbles are exactly FLUSH_DEPTH cycles.

STALL/FLUSH exceptions and ignored inputs:
- alu_exception is still evaluated and preempts: capture as overflow, halt=1, go to HALTED.
- Opcode and comparator are ignored.

HALTED:
- halt=1; all other control outputs are 0; all hazard inputs are ignored.
- resume causes a return to RUN at the next edge. Inputs in the resume cycle are not evaluated.
- ex_pc and ex_error_val are sticky; they are overwritten only by the next exception or by reset.

Arithmetic and timing:
- pc-2 and pc-4 are modulo 2^PC_W: pc=0x0000 with HALT gives ex_pc 0xFFFE; pc=0x0002 with overflow gives 0xFFFE.
- busy reflects the registered state only.
- rst asserted mid-STALL, mid-FLUSH or in HALTED forces RUN immediately and clears all registers.

Optional Feature:
- Macro: PIPE_HAZ_EXC_CNT_EN.
- Defined:
  - Adds output exc_count[7:0]: increments on every transition into HALTED and saturates at 0xFF.
  - Adds output stall_count[15:0]: counts every cycle with pc_bubble=1 and saturates at 0xFFFF.
  - Both clear on rst only.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- LOAD_LAT=3: idex_mem_read=1, idex_dest=5, ifid_op2=5 -> pc_bubble=mem_bubble=1 for exactly 3 cycles, busy=1 for cycles 2-3, then RUN.
- FLUSH_DEPTH=2: opcode 0110, comparator 11 -> change_pc=1 for 1 cycle, mem_bubble=1 for 2 cycles. Opcode 0110, comparator 01 -> no action.
- pc=0x0040 with opcode 0000 -> halt=1 the same cycle; next cycle ex_pc=0x003E, ex_error_val=0x0001. halt stays high for 10 cycles with no resume.
- During a FLUSH cycle, assert alu_exception with pc=0x0010 -> HALTED, ex_pc=0x000C, ex_error_val=0xAFFF. Resume pulse -> RUN with registers retained.
- opcode 0011, pc=0x0000 -> ex_pc=0xFFFE, ex_error_val=0xC000. Assert rst asynchronously mid-cycle -> halt=0 and ex registers 0 before the next clk edge.
- PIPE_HAZ_EXC_CNT_EN defined: 300 HALT/resume pairs -> exc_count=0xFF (saturated).
